// File: rtl/gpio_port_rg_if.sv
// gpio_port_rg_if: I/O-bus register access channel between the bus decoder
// (master) and a GPIO port register block (slave). rdata is combinational
// from addr on the slave side.
interface gpio_port_rg_if #(
    parameter int P_WIDTH = 8
);
    logic [2:0]         addr;
    logic               we;
    logic [P_WIDTH-1:0] wdata;
    logic [P_WIDTH-1:0] rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/gpio_port_rg.sv
// gpio_port_rg: one GPIO port register block (DDR, PORT, synchronised PIN
// with write-one-to-toggle, pin-change interrupt detector).
// Optional feature macro: GPIO_PCINT_EN. When defined, PCMSK/PCIF, the
// post-reset arm guard and pcint_irq are built. When undefined, addresses
// 3 and 4 behave as reserved, pcint_irq is tied low and pcint_ack is ignored.
// Register map: 0 PIN, 1 DDR, 2 PORT, 3 PCMSK, 4 PCIF, 5..7 reserved.
module gpio_port_rg #(
    parameter int                 P_WIDTH       = 8,
    parameter logic [P_WIDTH-1:0] P_INIT_PORT   = '0,
    parameter logic [P_WIDTH-1:0] P_INIT_DDR    = '0,
    parameter logic [P_WIDTH-1:0] P_IMPL_MASK   = '1,
    parameter int                 P_SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               nrst,
    gpio_port_rg_if.slave      bus,
    input  logic [P_WIDTH-1:0] pin_in,
    output logic [P_WIDTH-1:0] port_out,
    output logic [P_WIDTH-1:0] ddr_out,
    output logic               pcint_irq,
    input  logic               pcint_ack
);

    localparam logic [2:0] A_PIN   = 3'd0;
    localparam logic [2:0] A_DDR   = 3'd1;
    localparam logic [2:0] A_PORT  = 3'd2;
    localparam logic [2:0] A_PCMSK = 3'd3;
    localparam logic [2:0] A_PCIF  = 3'd4;

    // Write decodes
    logic w_wr_pin;
    logic w_wr_ddr;
    logic w_wr_port;

    assign w_wr_pin  = bus.we && (bus.addr == A_PIN);
    assign w_wr_ddr  = bus.we && (bus.addr == A_DDR);
    assign w_wr_port = bus.we && (bus.addr == A_PORT);

    // ------------------------------------------------------------------
    // Pin input synchroniser. Unimplemented bits are forced to 0 at the
    // input so those flops are constant and PIN reads 0 there.
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] r_sync   [P_SYNC_STAGES];
    logic [P_WIDTH-1:0] w_sync_d [P_SYNC_STAGES];
    logic [P_WIDTH-1:0] w_pin_sync;

    genvar gi;
    generate
        for (gi = 0; gi < P_SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_d[gi] = pin_in & P_IMPL_MASK;
            end else begin : g_rest
                assign w_sync_d[gi] = r_sync[gi-1];
            end

            // One synchroniser stage, cleared on reset
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_sync[gi] <= '0;
                end else begin
                    r_sync[gi] <= w_sync_d[gi];
                end
            end
        end
    endgenerate

    assign w_pin_sync = r_sync[P_SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // DDR and PORT registers
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] r_ddr;
    logic [P_WIDTH-1:0] r_port;

    // DDR loads on write; unimplemented bits stay 0
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ddr <= P_INIT_DDR & P_IMPL_MASK;
        end else if (w_wr_ddr) begin
            r_ddr <= bus.wdata & P_IMPL_MASK;
        end
    end

    // PORT loads on a PORT write, toggles on ones written to PIN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_port <= P_INIT_PORT & P_IMPL_MASK;
        end else if (w_wr_port) begin
            r_port <= bus.wdata & P_IMPL_MASK;
        end else if (w_wr_pin) begin
            r_port <= r_port ^ (bus.wdata & P_IMPL_MASK);
        end
    end

    assign port_out = r_port;
    assign ddr_out  = r_ddr;

`ifdef GPIO_PCINT_EN
    // ------------------------------------------------------------------
    // Pin-change interrupt detector
    // ------------------------------------------------------------------
    localparam int         ARM_CYCLES = P_SYNC_STAGES + 1;
    localparam logic [2:0] ARM_LAST   = 3'(ARM_CYCLES);

    logic               w_wr_pcmsk;
    logic               w_wr_pcif;
    logic [2:0]         r_arm_cnt;
    logic               w_armed;
    logic [P_WIDTH-1:0] r_prev;
    logic [P_WIDTH-1:0] r_pcmsk;
    logic [P_WIDTH-1:0] r_pcif;
    logic               r_irq;
    logic [P_WIDTH-1:0] w_change;
    logic [P_WIDTH-1:0] w_set;
    logic [P_WIDTH-1:0] w_clr;
    logic [P_WIDTH-1:0] w_pcif_next;

    assign w_wr_pcmsk = bus.we && (bus.addr == A_PCMSK);
    assign w_wr_pcif  = bus.we && (bus.addr == A_PCIF);

    // The synchroniser output is still settling from its reset zeros for
    // the first ARM_CYCLES edges; ignore changes until then.
    assign w_armed = (r_arm_cnt == ARM_LAST);

    // Saturating arm-guard counter, restarted by every reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    // Previous synchronised sample for edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_pin_sync;
        end
    end

    // Pin-change mask register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pcmsk <= '0;
        end else if (w_wr_pcmsk) begin
            r_pcmsk <= bus.wdata & P_IMPL_MASK;
        end
    end

    assign w_change    = w_pin_sync ^ r_prev;
    assign w_set       = w_armed ? (w_change & r_pcmsk & P_IMPL_MASK) : '0;
    assign w_clr       = (w_wr_pcif ? bus.wdata : '0) | {P_WIDTH{pcint_ack}};
    // A new change wins over a clear in the same cycle
    assign w_pcif_next = (r_pcif & ~w_clr) | w_set;

    // Flags and request register together so irq tracks PCIF with no lag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pcif <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pcif <= w_pcif_next;
            r_irq  <= |w_pcif_next;
        end
    end

    assign pcint_irq = r_irq;
`else
    logic w_unused_ack;
    assign w_unused_ack = pcint_ack;
    assign pcint_irq    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] w_rdata;

    // Select register by address; reserved addresses read 0
    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            A_PIN:   w_rdata = w_pin_sync;
            A_DDR:   w_rdata = r_ddr;
            A_PORT:  w_rdata = r_port;
`ifdef GPIO_PCINT_EN
            A_PCMSK: w_rdata = r_pcmsk;
            A_PCIF:  w_rdata = r_pcif;
`endif
            default: w_rdata = '0;
        endcase
    end

    assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_gpio_port_rg.sv
// tb_gpio_port_rg: directed test of gpio_port_rg (P_INIT_PORT=A5,
// P_IMPL_MASK=7F, P_SYNC_STAGES=2) against a behavioural history model,
// plus literal expectations. Follows GPIO_PCINT_EN the same way as the RTL.
module tb_gpio_port_rg;

    localparam int         S    = 2;
    localparam logic [7:0] IMPL = 8'h7F;
    localparam logic [7:0] INIT = 8'hA5;
`ifdef GPIO_PCINT_EN
    localparam bit PCINT = 1'b1;
`else
    localparam bit PCINT = 1'b0;
`endif

    logic       clk;
    logic       nrst = 1'b1;
    logic [7:0] pin_in;
    logic [7:0] port_out;
    logic [7:0] ddr_out;
    logic       pcint_irq;
    logic       pcint_ack;

    gpio_port_rg_if #(.P_WIDTH(8)) u_bus ();

    gpio_port_rg #(
        .P_WIDTH      (8),
        .P_INIT_PORT  (INIT),
        .P_INIT_DDR   (8'h00),
        .P_IMPL_MASK  (IMPL),
        .P_SYNC_STAGES(S)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (u_bus),
        .pin_in   (pin_in),
        .port_out (port_out),
        .ddr_out  (ddr_out),
        .pcint_irq(pcint_irq),
        .pcint_ack(pcint_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: PIN is the pin value sampled S edges back, a
    // change is a difference between consecutive PIN values, detection is
    // off for the first S+1 edges after reset release.
    // ------------------------------------------------------------------
    logic [7:0] m_port, m_ddr, m_pcmsk, m_pcif;
    logic [7:0] m_samp [0:3];
    int         m_k;

    function automatic logic [7:0] f_pcif_next(input logic [7:0] pcif, input logic [7:0] chg,
                                               input logic [7:0] msk, input bit armed,
                                               input bit wr_pcif, input logic [7:0] wd,
                                               input bit ack);
        logic [7:0] set_v;
        logic [7:0] clr_v;
        set_v = armed ? (chg & msk & IMPL) : 8'h00;
        clr_v = (wr_pcif ? wd : 8'h00) | (ack ? 8'hFF : 8'h00);
        return PCINT ? ((pcif & ~clr_v) | set_v) : 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_samp[S-1] & IMPL;
            3'd1:    return m_ddr;
            3'd2:    return m_port;
            3'd3:    return PCINT ? m_pcmsk : 8'h00;
            3'd4:    return PCINT ? m_pcif : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_port  <= INIT & IMPL;
            m_ddr   <= 8'h00;
            m_pcmsk <= 8'h00;
            m_pcif  <= 8'h00;
            for (int i = 0; i < 4; i++) m_samp[i] <= 8'h00;
            m_k     <= 0;
        end else begin
            m_pcif <= f_pcif_next(m_pcif, m_samp[S-1] ^ m_samp[S], m_pcmsk, (m_k >= S + 1),
                                  u_bus.we && (u_bus.addr == 3'd4), u_bus.wdata, pcint_ack);
            m_samp[0] <= pin_in;
            for (int i = 1; i < 4; i++) m_samp[i] <= m_samp[i-1];
            if (m_k < 100) m_k <= m_k + 1;
            if (u_bus.we) begin
                case (u_bus.addr)
                    3'd0: m_port <= m_port ^ (u_bus.wdata & IMPL);
                    3'd1: m_ddr  <= u_bus.wdata & IMPL;
                    3'd2: m_port <= u_bus.wdata & IMPL;
                    3'd3: if (PCINT) m_pcmsk <= u_bus.wdata & IMPL;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (nrst && chk_en) begin
            check("cmp_port", port_out, m_port);
            check("cmp_ddr", ddr_out, m_ddr);
            check("cmp_rdata", u_bus.rdata, m_read(u_bus.addr));
            check("cmp_irq", {7'b0, pcint_irq}, {7'b0, (m_pcif != 8'h00)});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        u_bus.addr  = a;
        u_bus.wdata = d;
        u_bus.we    = 1'b1;
        tick(1);
        u_bus.we    = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [7:0] exp);
        u_bus.addr = a;
        #1;
        check(name, u_bus.rdata, exp);
    endtask

    initial begin
        pin_in      = 8'h00;
        pcint_ack   = 1'b0;
        u_bus.addr  = 3'd0;
        u_bus.we    = 1'b0;
        u_bus.wdata = 8'h00;

        // Reset values
        #3 nrst = 1'b0;
        tick(3);
        check("rst_port_out", port_out, 8'h25);
        check("rst_ddr_out", ddr_out, 8'h00);
        check("rst_irq", {7'b0, pcint_irq}, 8'h00);
        rd_check("rst_port_read", 3'd2, 8'h25);
        nrst   = 1'b1;
        chk_en = 1'b1;

        // PORT load, PIN toggle, implemented-bit masking
        wr(3'd2, 8'h0F);
        check("port_load", port_out, 8'h0F);
        wr(3'd0, 8'h3C);
        check("pin_toggle", port_out, 8'h33);
        check("toggle_ddr_hold", ddr_out, 8'h00);
        wr(3'd2, 8'hFF);
        check("port_impl_mask", port_out, 8'h7F);
        wr(3'd1, 8'hA5);
        check("ddr_load", ddr_out, 8'h25);
        wr(3'd6, 8'hFF);
        rd_check("reserved_read", 3'd6, 8'h00);

        // Synchroniser latency and first pin-change interrupt
`ifdef GPIO_PCINT_EN
        wr(3'd3, 8'h04);
        rd_check("pcmsk_read", 3'd3, 8'h04);
`endif
        u_bus.addr = 3'd0;
        pin_in     = 8'h04;
        tick(1);
        check("pin_not_before", u_bus.rdata, 8'h00);
        tick(1);
        check("pin_after_2", u_bus.rdata, 8'h04);
        check("irq_not_yet", {7'b0, pcint_irq}, 8'h00);
        tick(1);
`ifdef GPIO_PCINT_EN
        check("irq_rise_3", {7'b0, pcint_irq}, 8'h01);
        rd_check("pcif_set", 3'd4, 8'h04);
        wr(3'd4, 8'h04);
        check("irq_w1c_fall", {7'b0, pcint_irq}, 8'h00);
        rd_check("pcif_cleared", 3'd4, 8'h00);

        // Acknowledge colliding with a new change: set wins
        pin_in = 8'h00;
        tick(2);
        pcint_ack = 1'b1;
        tick(1);
        pcint_ack = 1'b0;
        check("ack_collide_irq", {7'b0, pcint_irq}, 8'h01);
        rd_check("ack_collide_pcif", 3'd4, 8'h04);
        pcint_ack = 1'b1;
        tick(1);
        pcint_ack = 1'b0;
        check("ack_clear_irq", {7'b0, pcint_irq}, 8'h00);

        // W1C colliding with a new change, then W1C of 0 holds
        pin_in = 8'h04;
        tick(2);
        wr(3'd4, 8'h04);
        check("w1c_collide_irq", {7'b0, pcint_irq}, 8'h01);
        wr(3'd4, 8'h00);
        check("w1c_zero_hold", {7'b0, pcint_irq}, 8'h01);
        wr(3'd4, 8'h04);
        check("w1c_clear", {7'b0, pcint_irq}, 8'h00);

        // Unimplemented bit never flags
        wr(3'd3, 8'hFF);
        rd_check("pcmsk_impl", 3'd3, 8'h7F);
        pin_in = 8'h84;
        tick(4);
        check("unimpl_no_irq", {7'b0, pcint_irq}, 8'h00);
        rd_check("unimpl_pin_read", 3'd0, 8'h04);
`else
        check("irq_tied_low", {7'b0, pcint_irq}, 8'h00);
        wr(3'd3, 8'hFF);
        rd_check("addr3_reserved", 3'd3, 8'h00);
        wr(3'd4, 8'hFF);
        rd_check("addr4_reserved", 3'd4, 8'h00);
        pcint_ack = 1'b1;
        pin_in    = 8'h84;
        tick(4);
        pcint_ack = 1'b0;
        check("irq_stays_low", {7'b0, pcint_irq}, 8'h00);
        rd_check("unimpl_pin_read", 3'd0, 8'h04);
`endif

        // Mid-operation reset with pins held high: no spurious flag
        wr(3'd1, 8'h5A);
        check("ddr_before_rst", ddr_out, 8'h5A);
        pin_in = 8'hFF;
        nrst   = 1'b0;
        #1;
        check("async_rst_ddr", ddr_out, 8'h00);
        tick(3);
        check("rst2_port_out", port_out, 8'h25);
        check("rst2_irq", {7'b0, pcint_irq}, 8'h00);
        nrst = 1'b1;
        wr(3'd3, 8'hFF);
        tick(6);
        check("no_spurious_irq", {7'b0, pcint_irq}, 8'h00);
        rd_check("no_spurious_pcif", 3'd4, 8'h00);
        rd_check("pin_high_read", 3'd0, 8'h7F);

        // A genuine change after arming still detected (or ignored if built out)
        pin_in = 8'hFB;
        tick(4);
`ifdef GPIO_PCINT_EN
        check("armed_detect", {7'b0, pcint_irq}, 8'h01);
`else
        check("armed_no_irq", {7'b0, pcint_irq}, 8'h00);
`endif
        tick(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_port_rg.md
# gpio_port_rg

Parametrised GPIO port register block, the successor to the single-register port model in the ATmega328PB GPIO subsystem. One instance implements a whole port: data direction (DDR), output latch (PORT), synchronised pin input (PIN) with write-one-to-toggle, and a pin-change interrupt detector (mask, flag, request). It sits between the internal I/O-bus decoder and the pad ring. One instance is used per port (B, C, D, E), with the width and implemented-bit mask set per port.

## Interface
- P_WIDTH, 8, port width in bits (1..8)
- P_INIT_PORT, all 0, PORT reset value
- P_INIT_DDR, all 0, DDR reset value
- P_IMPL_MASK, all 1, implemented bits
  - Unimplemented bits read 0, ignore writes, never flag.
- P_SYNC_STAGES, 2, pin input synchroniser depth (2..3)

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- addr  in  3  register select: 0 PIN, 1 DDR, 2 PORT, 3 PCMSK, 4 PCIF; 5..7 reserved
- we  in  1  write strobe, one clk cycle per access
- wdata  in  P_WIDTH  write data
- rdata  out  P_WIDTH  read data, combinational from addr
- pin_in  in  P_WIDTH  asynchronous pad inputs
- port_out  out  P_WIDTH  PORT register, drives pad output/pull-up
- ddr_out  out  P_WIDTH  DDR register, drives pad output enable
- pcint_irq  out  1  OR of all PCIF bits
- pcint_ack  in  1  interrupt-acknowledge pulse from the vector logic; clears all PCIF bits

## Operation
- Reset values:
  - port_out = P_INIT_PORT & P_IMPL_MASK
  - ddr_out = P_INIT_DDR & P_IMPL_MASK
  - PCMSK = 0, PCIF = 0, pcint_irq = 0
  - synchroniser chain and previous-sample register = 0
- Write to DDR or PORT with we=1: the register loads wdata on implemented bits.
- Write to PIN with we=1: each PORT bit i with wdata[i]=1 toggles. Bits with wdata[i]=0 hold. DDR is unaffected.
- PCMSK is read/write.
- Write to PCIF: each bit written 1 clears, each bit written 0 holds.
- Writes to reserved addresses are ignored. Reads of reserved addresses return 0.
- Read of PIN returns the last synchroniser stage, not pin_in directly.
- Pin-change detection:
  - change[i] = sync[i] XOR prev[i], with prev loaded from sync every cycle.
  - PCIF[i] sets when change[i] & PCMSK[i] & P_IMPL_MASK[i].
- Arm guard: detection is disabled for P_SYNC_STAGES+1 cycles after reset release, so pins held high at reset do not raise a spurious flag. This is implemented with a small counter that saturates.
- Priority per PCIF bit: set beats clear. A new change in the same cycle as a W1C write or pcint_ack leaves the bit 1.
- pcint_irq = |PCIF, registered. It is the same cycle as PCIF, with no extra stage.
- Reset mid-operation returns every register to its reset value immediately (async) and restarts the arm guard.

## Timing
- Register writes take effect at the clk edge where we=1. The new value is visible on rdata/port_out/ddr_out in the following cycle.
- pin_in to PIN readback: P_SYNC_STAGES clk edges.
- pin_in edge to PCIF/pcint_irq high: P_SYNC_STAGES+1 edges.
- PCIF W1C or pcint_ack to pcint_irq low: 1 edge, provided no other flag is set.
- Pulses on pin_in shorter than one clk period may be missed. This is not required to be detected.

## Configuration
- GPIO_PCINT_EN defined: PCMSK, PCIF, the arm guard and pcint_irq are implemented as above.
- GPIO_PCINT_EN undefined:
  - The detector logic is removed.
  - Addresses 3 and 4 behave as reserved (read 0, writes ignored).
  - pcint_irq is tied 0 and pcint_ack is ignored.
  - The synchroniser and PIN readback remain.

## Test plan
- Reset with P_INIT_PORT=8'hA5, P_IMPL_MASK=8'h7F: port_out=8'h25, ddr_out=0, pcint_irq=0; PORT readback = 8'h25.
- Write PORT=8'h0F, then PIN=8'h3C: port_out goes 8'h0F then 8'h33; DDR unchanged.
- pin_in 0 -> 8'h04 with P_SYNC_STAGES=2: PIN reads 8'h04 exactly 2 edges later and not before.
- PCMSK=8'h04, toggle pin_in[2]: pcint_irq rises 3 edges after the change. Write PCIF=8'h04: irq falls next edge.
- Assert pcint_ack in the same cycle a new masked change is detected: PCIF stays 1 and pcint_irq stays 1.
- pin_in=8'hFF held through reset, PCMSK=8'hFF after release: no PCIF set. Build without GPIO_PCINT_EN: reading addr 3/4 returns 0 and pcint_irq stays 0.
